id_stage_bypass: RTL and testbench
==================================

// Module: id_stage_bypass
// PURPOSE
//  Decode stage of the 5-stage MIPS pipeline: next generation of the decode stage, parametrised in data width and bypass depth.
//  Latches {inst,pc} from IF and decodes the lab-3 subset (addu subu slt sltu and or xor nor sll srl sra addiu lui lw sw beq bne jal jr).
//  Reads the integrated regfile and resolves RAW hazards by forwarding from FWD_SRCS younger stages plus WB.
//  Applies a load-use interlock, then issues to EX and resolves branches/jumps towards IF only once operands are final.
// PARAMETERS
//  DATA_W    32  register / datapath width; pc stays 32 bit
//  FWD_SRCS  2   number of forwarding sources on fwd_bus; index 0 = EX (youngest), 1 = MEM, ...
//  FWD_ENT_W DATA_W+8  derived entry width {valid, we, data_ok, dest[4:0], data[DATA_W-1:0]}; do not override
// PORTS
//  clk             in   1                    clock
//  reset           in   1                    synchronous, active-high
//  es_allowin      in   1                    EX can accept this cycle
//  ds_allowin      out  1                    ID can accept this cycle
//  fs_to_ds_valid  in   1                    IF payload valid
//  fs_to_ds_bus    in   64                   {inst[31:0], pc[31:0]}
//  ds_to_es_valid  out  1                    ID payload valid to EX
//  ds_to_es_bus    out  104+2*DATA_W         {alu_op[11:0],load_op,src1_is_sa,src1_is_pc,src2_is_imm,src2_is_8,gr_we,mem_we,dest[4:0],imm[15:0],rs_val,rt_val,pc[31:0]}
//  br_bus          out  33                   {br_taken, br_target[31:0]}
//  ws_to_rf_bus    in   6+DATA_W             {we, waddr[4:0], wdata}
//  fwd_bus         in   FWD_SRCS*FWD_ENT_W   packed forwarding entries, entry 0 in the LSBs
//  stall_cnt       out  32                   count of cycles with ds_valid && !ds_ready_go
// BEHAVIOUR
//  - Reset: ds_valid=0, stall_cnt=0, br_taken=0. Payload register is not reset; outputs are qualified by ds_valid.
//  - Handshake: ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
//    - On ds_allowin, ds_valid <= fs_to_ds_valid. The payload loads only on fs_to_ds_valid && ds_allowin.
//    - ds_to_es_valid = ds_valid && ds_ready_go. Latency IF->EX is 1 cycle when there is no stall.
//  - Operand selection, per source (rs, rt), with priority first match wins:
//    - fwd entry 0..FWD_SRCS-1 with valid && we && dest==src;
//    - then WB (ws we && waddr==src);
//    - then regfile.
//    - src==0 never matches and always reads 0.
//  - Hazard:
//    - A matched fwd entry with data_ok=0 (load in flight) makes the operand not ready.
//    - ds_ready_go = !(rs_used && rs_not_ready) && !(rt_used && rt_not_ready).
//    - rs_used: every instruction except sll/srl/sra/lui/jal. rt_used: R-type ALU ops, sll/srl/sra, sw, beq, bne.
//  - Branch:
//    - br_taken = ds_valid && ds_ready_go && (beq&eq | bne&!eq | jal | jr). It is combinational and never asserted while stalled.
//    - Target for beq/bne is pc+4+sext(imm)<<2. jal uses {pc4[31:28],jidx,2'b0}. jr uses the forwarded rs_val[31:0].
//  - stall_cnt increments on every ds_valid && !ds_ready_go cycle and wraps 0xFFFFFFFF -> 0.
//  - Simultaneous regfile write and read of the same register returns the new data via the WB bypass.
//  - reset mid-stall clears ds_valid; nothing issues on the following cycle.
//  - Stall held while es_allowin=0: payload and outputs stay stable.
// CONFIGURATION
//  ID_BYPASS_FWD_EN defined:
//    - full forwarding as above; only data_ok=0 stalls.
//  ID_BYPASS_FWD_EN undefined:
//    - fwd_bus data is ignored for selection (WB bypass kept);
//    - any valid && we && dest match in any fwd entry makes the operand not ready, i.e. full interlock until WB.
//    - Ports are unchanged.
// TESTING
//  1 reset=1 for 3 cycles, fs_to_ds_valid=1 -> ds_valid=0, ds_to_es_valid=0, br_taken=0, stall_cnt=0.
//  2 addu $3,$1,$2 with EX entry {v,we,ok,dest=1,data=5} and MEM entry {dest=2,data=7} -> rs_val=5, rt_val=7, no stall (FWD_EN).
//  3 lw $4 in EX (data_ok=0) followed by addu $5,$4,$4 -> exactly 1 stall cycle, stall_cnt=1; issue with rs=rt=MEM data on next cycle.
//  4 beq $1,$1,+3 at pc=0x100 with $1 forwarded -> br_taken=1, target=0x110. Under a stall, br_taken stays 0 until operands are ready.
//  5 jr $31 with WB writing $31=0xBFC00200 in the same cycle -> br_target=0xBFC00200.
//  6 FWD_EN undefined, EX entry dest=1 ok=1 and addu uses $1 -> stalls until the entry leaves and WB writes. es_allowin=0 holds the payload stable.

Source files
------------

// File: rtl/id_stage_bypass.sv
// id_stage_bypass: MIPS decode stage with integrated regfile, multi-source
// operand bypass, load-use interlock and branch/jump resolution.
// Optional feature macro: ID_BYPASS_FWD_EN
//   defined   -> operands are taken from fwd_bus; only data_ok=0 stalls
//   undefined -> fwd_bus data is ignored; any matching fwd entry interlocks
//                until the value reaches WB (ports are identical)
// ds_to_es_bus carries 32 reserved MSBs above the issue payload, driven to 0.

module id_stage_bypass #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FWD_SRCS  = 2,
    parameter int unsigned FWD_ENT_W = DATA_W + 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          es_allowin,
    output logic                          ds_allowin,
    input  logic                          fs_to_ds_valid,
    input  logic [63:0]                   fs_to_ds_bus,
    output logic                          ds_to_es_valid,
    output logic [104+2*DATA_W-1:0]       ds_to_es_bus,
    output logic [32:0]                   br_bus,
    input  logic [6+DATA_W-1:0]           ws_to_rf_bus,
    input  logic [FWD_SRCS*FWD_ENT_W-1:0] fwd_bus,
    output logic [31:0]                   stall_cnt
);

    localparam int unsigned ES_BUS_W  = 104 + 2 * DATA_W;
    localparam int unsigned PAYLOAD_W = 72 + 2 * DATA_W;
    localparam int unsigned PAD_W     = ES_BUS_W - PAYLOAD_W;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic              data_ok;
        logic [4:0]        dest;
        logic [DATA_W-1:0] data;
    } fwd_ent_t;

    typedef struct packed {
        logic [11:0]       alu_op;
        logic              load_op;
        logic              src1_is_sa;
        logic              src1_is_pc;
        logic              src2_is_imm;
        logic              src2_is_8;
        logic              gr_we;
        logic              mem_we;
        logic [4:0]        dest;
        logic [15:0]       imm;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [31:0]       pc;
    } es_payload_t;

    logic              ds_valid;
    logic              ds_ready_go;
    logic [31:0]       ds_inst;
    logic [31:0]       ds_pc;

    logic [DATA_W-1:0] rf [32];

    logic              ws_we;
    logic [4:0]        ws_waddr;
    logic [DATA_W-1:0] ws_wdata;

    fwd_ent_t          fwd_ent [FWD_SRCS];

    logic [4:0]        opnd_src [2];
    logic [DATA_W-1:0] opnd_val [2];
    logic              opnd_nr  [2];

    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] jidx;

    logic inst_addu, inst_subu, inst_slt, inst_sltu;
    logic inst_and, inst_or, inst_xor, inst_nor;
    logic inst_sll, inst_srl, inst_sra, inst_jr;
    logic inst_addiu, inst_lui, inst_lw, inst_sw;
    logic inst_beq, inst_bne, inst_jal;
    logic is_alu_r, is_shift;
    logic rs_used, rt_used;
    logic gr_we;
    logic [4:0] dest;

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              rs_eq_rt;
    logic [31:0]       pc4;
    logic [31:0]       br_off;
    logic              br_taken;
    logic [31:0]       br_target;

    es_payload_t       es_payload;

    // WB write port fields
    assign ws_we    = ws_to_rf_bus[DATA_W+5];
    assign ws_waddr = ws_to_rf_bus[DATA_W+4:DATA_W];
    assign ws_wdata = ws_to_rf_bus[DATA_W-1:0];

    // Handshake towards IF and EX
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go;

    // Valid bit of the decode slot
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid;
        end
    end

    // Instruction/pc payload, loaded only when a new instruction is accepted
    always_ff @(posedge clk) begin
        if (fs_to_ds_valid && ds_allowin) begin
            {ds_inst, ds_pc} <= fs_to_ds_bus;
        end
    end

    // Register file write; $0 is never stored
    always_ff @(posedge clk) begin
        if (ws_we && (ws_waddr != 5'd0)) begin
            rf[ws_waddr] <= ws_wdata;
        end
    end

    // Count cycles in which a valid instruction is held back by a hazard
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (ds_valid && !ds_ready_go) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Field extraction
    assign op   = ds_inst[31:26];
    assign rs   = ds_inst[25:21];
    assign rt   = ds_inst[20:16];
    assign rd   = ds_inst[15:11];
    assign func = ds_inst[5:0];
    assign imm  = ds_inst[15:0];
    assign jidx = ds_inst[25:0];

    // Instruction decode of the supported subset
    always_comb begin
        inst_addu  = (op == OP_SPECIAL) && (func == FN_ADDU);
        inst_subu  = (op == OP_SPECIAL) && (func == FN_SUBU);
        inst_slt   = (op == OP_SPECIAL) && (func == FN_SLT);
        inst_sltu  = (op == OP_SPECIAL) && (func == FN_SLTU);
        inst_and   = (op == OP_SPECIAL) && (func == FN_AND);
        inst_or    = (op == OP_SPECIAL) && (func == FN_OR);
        inst_xor   = (op == OP_SPECIAL) && (func == FN_XOR);
        inst_nor   = (op == OP_SPECIAL) && (func == FN_NOR);
        inst_sll   = (op == OP_SPECIAL) && (func == FN_SLL);
        inst_srl   = (op == OP_SPECIAL) && (func == FN_SRL);
        inst_sra   = (op == OP_SPECIAL) && (func == FN_SRA);
        inst_jr    = (op == OP_SPECIAL) && (func == FN_JR);
        inst_addiu = (op == OP_ADDIU);
        inst_lui   = (op == OP_LUI);
        inst_lw    = (op == OP_LW);
        inst_sw    = (op == OP_SW);
        inst_beq   = (op == OP_BEQ);
        inst_bne   = (op == OP_BNE);
        inst_jal   = (op == OP_JAL);
        is_alu_r   = inst_addu | inst_subu | inst_slt | inst_sltu
                   | inst_and  | inst_or   | inst_xor | inst_nor;
        is_shift   = inst_sll | inst_srl | inst_sra;
    end

    // Operand usage, write-back enable and destination register
    always_comb begin
        rs_used = !(is_shift | inst_lui | inst_jal);
        rt_used = is_alu_r | is_shift | inst_sw | inst_beq | inst_bne;
        gr_we   = is_alu_r | is_shift | inst_addiu | inst_lui | inst_lw | inst_jal;
        dest    = 5'd0;
        if (inst_jal) begin
            dest = 5'd31;
        end else if (inst_addiu | inst_lui | inst_lw) begin
            dest = rt;
        end else if (gr_we) begin
            dest = rd;
        end
    end

    // Unpack the forwarding bus, entry 0 (youngest) in the LSBs
    always_comb begin
        for (int i = 0; i < FWD_SRCS; i++) begin
            fwd_ent[i] = fwd_bus[i*FWD_ENT_W +: FWD_ENT_W];
        end
    end

    assign opnd_src[0] = rs;
    assign opnd_src[1] = rt;

    // Operand selection: youngest matching fwd entry, then WB, then regfile
    always_comb begin
        logic              hit;
        logic [DATA_W-1:0] base;
`ifdef ID_BYPASS_FWD_EN
        logic [DATA_W-1:0] hit_data;
        logic              hit_ok;
`endif
        for (int k = 0; k < 2; k++) begin
            opnd_val[k] = '0;
            opnd_nr[k]  = 1'b0;
            hit         = 1'b0;
            base        = '0;
`ifdef ID_BYPASS_FWD_EN
            hit_data    = '0;
            hit_ok      = 1'b0;
`endif
            if (opnd_src[k] != 5'd0) begin
                for (int i = 0; i < FWD_SRCS; i++) begin
                    if (!hit && fwd_ent[i].valid && fwd_ent[i].we
                            && (fwd_ent[i].dest == opnd_src[k])) begin
                        hit = 1'b1;
`ifdef ID_BYPASS_FWD_EN
                        hit_data = fwd_ent[i].data;
                        hit_ok   = fwd_ent[i].data_ok;
`endif
                    end
                end
                if (ws_we && (ws_waddr == opnd_src[k])) begin
                    base = ws_wdata;
                end else begin
                    base = rf[opnd_src[k]];
                end
`ifdef ID_BYPASS_FWD_EN
                opnd_val[k] = hit ? hit_data : base;
                opnd_nr[k]  = hit && !hit_ok;
`else
                opnd_val[k] = base;
                opnd_nr[k]  = hit;
`endif
            end
        end
    end

`ifndef ID_BYPASS_FWD_EN
    // Forwarded data is not consumed when full interlock is selected
    logic unused_fwd;
    always_comb begin
        unused_fwd = 1'b0;
        for (int i = 0; i < FWD_SRCS; i++) begin
            unused_fwd = unused_fwd ^ (^{fwd_ent[i].data_ok, fwd_ent[i].data});
        end
    end
`endif

    assign rs_val      = opnd_val[0];
    assign rt_val      = opnd_val[1];
    assign ds_ready_go = !(rs_used && opnd_nr[0]) && !(rt_used && opnd_nr[1]);

    // Branch/jump resolution, only once the operands are final
    always_comb begin
        rs_eq_rt  = (rs_val == rt_val);
        pc4       = ds_pc + 32'd4;
        br_off    = {{14{imm[15]}}, imm, 2'b00};
        br_taken  = ds_valid && ds_ready_go
                 && ((inst_beq && rs_eq_rt) || (inst_bne && !rs_eq_rt)
                     || inst_jal || inst_jr);
        br_target = 32'(rs_val);
        if (inst_beq || inst_bne) begin
            br_target = pc4 + br_off;
        end else if (inst_jal) begin
            br_target = {pc4[31:28], jidx, 2'b00};
        end
    end

    assign br_bus = {br_taken, br_target};

    // Issue payload towards EX
    always_comb begin
        es_payload             = '0;
        es_payload.alu_op[0]   = inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal;
        es_payload.alu_op[1]   = inst_subu;
        es_payload.alu_op[2]   = inst_slt;
        es_payload.alu_op[3]   = inst_sltu;
        es_payload.alu_op[4]   = inst_and;
        es_payload.alu_op[5]   = inst_nor;
        es_payload.alu_op[6]   = inst_or;
        es_payload.alu_op[7]   = inst_xor;
        es_payload.alu_op[8]   = inst_sll;
        es_payload.alu_op[9]   = inst_srl;
        es_payload.alu_op[10]  = inst_sra;
        es_payload.alu_op[11]  = inst_lui;
        es_payload.load_op     = inst_lw;
        es_payload.src1_is_sa  = is_shift;
        es_payload.src1_is_pc  = inst_jal;
        es_payload.src2_is_imm = inst_addiu | inst_lui | inst_lw | inst_sw;
        es_payload.src2_is_8   = inst_jal;
        es_payload.gr_we       = gr_we;
        es_payload.mem_we      = inst_sw;
        es_payload.dest        = dest;
        es_payload.imm         = imm;
        es_payload.rs_val      = rs_val;
        es_payload.rt_val      = rt_val;
        es_payload.pc          = ds_pc;
    end

    assign ds_to_es_bus = {{PAD_W{1'b0}}, es_payload};

endmodule

// File: tb/tb_id_stage_bypass.sv
// Directed bench for id_stage_bypass (DATA_W=32, FWD_SRCS=2).
// Expectations follow the build: ID_BYPASS_FWD_EN selects the forwarding paths.

module tb_id_stage_bypass;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FWD_N  = 2;
    localparam int unsigned ENT_W  = DATA_W + 8;

    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] O_BEQ  = 6'h04;
    localparam logic [5:0] O_BNE  = 6'h05;
    localparam logic [ENT_W-1:0] NO_ENT = 40'd0;

    logic                      clk;
    logic                      reset;
    logic                      es_allowin;
    logic                      ds_allowin;
    logic                      fs_to_ds_valid;
    logic [63:0]               fs_to_ds_bus;
    logic                      ds_to_es_valid;
    logic [104+2*DATA_W-1:0]   ds_to_es_bus;
    logic [32:0]               br_bus;
    logic [6+DATA_W-1:0]       ws_to_rf_bus;
    logic [FWD_N*ENT_W-1:0]    fwd_bus;
    logic [31:0]               stall_cnt;

    int checks;
    int failures;
    int exp_stall;

    logic [31:0] b_pc, b_rt, b_rs, br_target;
    logic [4:0]  b_dest;
    logic [11:0] b_alu;
    logic        b_src1_pc, b_gr_we, br_taken;

    assign b_pc      = ds_to_es_bus[31:0];
    assign b_rt      = ds_to_es_bus[63:32];
    assign b_rs      = ds_to_es_bus[95:64];
    assign b_dest    = ds_to_es_bus[116:112];
    assign b_gr_we   = ds_to_es_bus[118];
    assign b_src1_pc = ds_to_es_bus[121];
    assign b_alu     = ds_to_es_bus[135:124];
    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    id_stage_bypass #(.DATA_W(DATA_W), .FWD_SRCS(FWD_N)) dut (
        .clk            (clk),
        .reset          (reset),
        .es_allowin     (es_allowin),
        .ds_allowin     (ds_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .br_bus         (br_bus),
        .ws_to_rf_bus   (ws_to_rf_bus),
        .fwd_bus        (fwd_bus),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load(input logic [31:0] inst, input logic [31:0] pc);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {inst, pc};
        tick();
        fs_to_ds_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        ws_to_rf_bus = {1'b1, addr, data};
        tick();
        ws_to_rf_bus = '0;
    endtask

    function automatic logic [ENT_W-1:0] fwd_e(input logic v, input logic we, input logic ok,
                                               input logic [4:0] d, input logic [31:0] data);
        return {v, we, ok, d, data};
    endfunction

    function automatic logic [31:0] r_inst(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        checks = 0; failures = 0; exp_stall = 0;
        reset = 1'b1; es_allowin = 1'b1;
        fs_to_ds_valid = 1'b1; fs_to_ds_bus = {r_inst(5'd1, 5'd2, 5'd3, F_ADDU), 32'h0};
        ws_to_rf_bus = '0; fwd_bus = '0;

        // reset held with IF offering an instruction
        repeat (3) tick();
        check_eq("rst_es_valid",  64'(ds_to_es_valid), 64'd0);
        check_eq("rst_br_taken",  64'(br_taken),       64'd0);
        check_eq("rst_stall_cnt", 64'(stall_cnt),      64'd0);
        reset = 1'b0; fs_to_ds_valid = 1'b0;
        tick();
        check_eq("post_rst_allowin",  64'(ds_allowin),     64'd1);
        check_eq("post_rst_es_valid", 64'(ds_to_es_valid), 64'd0);

        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);
        wb_write(5'd6, 32'h66);

        // plain regfile read, one-cycle latency
        load(r_inst(5'd1, 5'd2, 5'd3, F_ADDU), 32'h1000);
        settle();
        check_eq("rf_valid", 64'(ds_to_es_valid), 64'd1);
        check_eq("rf_rs",    64'(b_rs),   64'h11);
        check_eq("rf_rt",    64'(b_rt),   64'h22);
        check_eq("rf_dest",  64'(b_dest), 64'd3);
        check_eq("rf_gr_we", 64'(b_gr_we), 64'd1);
        check_eq("rf_alu",   64'(b_alu),  64'h001);
        check_eq("rf_pc",    64'(b_pc),   64'h1000);

        // $0 never matches a fwd entry and reads 0
        load(r_inst(5'd0, 5'd6, 5'd7, F_SUBU), 32'h1004);
        fwd_bus = {NO_ENT, fwd_e(1'b1, 1'b1, 1'b0, 5'd0, 32'hdead)};
        settle();
        check_eq("zero_valid", 64'(ds_to_es_valid), 64'd1);
        check_eq("zero_rs",    64'(b_rs),  64'h0);
        check_eq("zero_rt",    64'(b_rt),  64'h66);
        check_eq("zero_alu",   64'(b_alu), 64'h002);
        fwd_bus = '0;

        // WB write in the same cycle beats the regfile
        load(r_inst(5'd1, 5'd2, 5'd3, F_ADDU), 32'h1008);
        ws_to_rf_bus = {1'b1, 5'd2, 32'h77};
        settle();
        check_eq("wb_rt", 64'(b_rt), 64'h77);
        check_eq("wb_rs", 64'(b_rs), 64'h11);
        ws_to_rf_bus = '0;

        // rs from EX, rt from MEM
        load(r_inst(5'd1, 5'd2, 5'd3, F_ADDU), 32'h100C);
        fwd_bus = {fwd_e(1'b1, 1'b1, 1'b1, 5'd2, 32'd7), fwd_e(1'b1, 1'b1, 1'b1, 5'd1, 32'd5)};
        settle();
`ifdef ID_BYPASS_FWD_EN
        check_eq("fwd_valid", 64'(ds_to_es_valid), 64'd1);
        check_eq("fwd_rs",    64'(b_rs), 64'd5);
        check_eq("fwd_rt",    64'(b_rt), 64'd7);
`else
        check_eq("ilk_valid",   64'(ds_to_es_valid), 64'd0);
        check_eq("ilk_allowin", 64'(ds_allowin),     64'd0);
        tick(); exp_stall++;
        fwd_bus = {fwd_e(1'b1, 1'b1, 1'b1, 5'd1, 32'd5), NO_ENT};
        settle();
        check_eq("ilk_mem_valid", 64'(ds_to_es_valid), 64'd0);
        tick(); exp_stall++;
        fwd_bus = '0;
        ws_to_rf_bus = {1'b1, 5'd1, 32'h11};
        settle();
        check_eq("ilk_wb_valid", 64'(ds_to_es_valid), 64'd1);
        check_eq("ilk_wb_rs",    64'(b_rs), 64'h11);
        check_eq("ilk_wb_rt",    64'(b_rt), 64'h22);
`endif
        check_eq("fwd_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        fwd_bus = '0; ws_to_rf_bus = '0;

`ifdef ID_BYPASS_FWD_EN
        // EX wins over MEM; an entry without we is skipped
        load(r_inst(5'd1, 5'd1, 5'd3, F_ADDU), 32'h1010);
        fwd_bus = {fwd_e(1'b1, 1'b1, 1'b1, 5'd1, 32'hB), fwd_e(1'b1, 1'b1, 1'b1, 5'd1, 32'hA)};
        settle();
        check_eq("prio_rs", 64'(b_rs), 64'hA);
        fwd_bus = {fwd_e(1'b1, 1'b1, 1'b1, 5'd1, 32'hB), fwd_e(1'b1, 1'b0, 1'b1, 5'd1, 32'hA)};
        settle();
        check_eq("prio_we_rs", 64'(b_rs), 64'hB);
        fwd_bus = '0;
`endif

        // load-use: lw $4 in EX, then addu $5,$4,$4
        load(r_inst(5'd4, 5'd4, 5'd5, F_ADDU), 32'h1020);
        fwd_bus = {NO_ENT, fwd_e(1'b1, 1'b1, 1'b0, 5'd4, 32'h0)};
        settle();
        check_eq("lu_stall_valid",   64'(ds_to_es_valid), 64'd0);
        check_eq("lu_stall_allowin", 64'(ds_allowin),     64'd0);
        check_eq("lu_stall_br",      64'(br_taken),       64'd0);
        tick(); exp_stall++;
        fwd_bus = {fwd_e(1'b1, 1'b1, 1'b1, 5'd4, 32'h1234), NO_ENT};
        settle();
`ifdef ID_BYPASS_FWD_EN
        check_eq("lu_valid", 64'(ds_to_es_valid), 64'd1);
        check_eq("lu_rs",    64'(b_rs), 64'h1234);
        check_eq("lu_rt",    64'(b_rt), 64'h1234);
`else
        check_eq("lu_mem_valid", 64'(ds_to_es_valid), 64'd0);
        tick(); exp_stall++;
        fwd_bus = '0;
        ws_to_rf_bus = {1'b1, 5'd4, 32'h1234};
        settle();
        check_eq("lu_valid", 64'(ds_to_es_valid), 64'd1);
        check_eq("lu_rs",    64'(b_rs), 64'h1234);
        check_eq("lu_rt",    64'(b_rt), 64'h1234);
`endif
        check_eq("lu_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        fwd_bus = '0; ws_to_rf_bus = '0;

        // beq $1,$1,+3 at 0x100: suppressed while stalled, then taken to 0x110
        load(i_inst(O_BEQ, 5'd1, 5'd1, 16'd3), 32'h100);
        fwd_bus = {NO_ENT, fwd_e(1'b1, 1'b1, 1'b0, 5'd1, 32'h0)};
        settle();
        check_eq("beq_stall_taken", 64'(br_taken),       64'd0);
        check_eq("beq_stall_valid", 64'(ds_to_es_valid), 64'd0);
        tick(); exp_stall++;
        fwd_bus = {NO_ENT, fwd_e(1'b1, 1'b1, 1'b1, 5'd1, 32'h99)};
        settle();
`ifndef ID_BYPASS_FWD_EN
        check_eq("beq_ilk_taken", 64'(br_taken), 64'd0);
        tick(); exp_stall++;
        fwd_bus = '0;
        settle();
`endif
        check_eq("beq_taken",  64'(br_taken),  64'd1);
        check_eq("beq_target", 64'(br_target), 64'h110);
        check_eq("beq_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        fwd_bus = '0;

        // bne on equal operands falls through
        load(i_inst(O_BNE, 5'd1, 5'd1, 16'd4), 32'h200);
        settle();
        check_eq("bne_valid", 64'(ds_to_es_valid), 64'd1);
        check_eq("bne_taken", 64'(br_taken),       64'd0);

        // jal does not read rs even though its index bits alias a pending dest
        load({6'h03, 26'h0200100}, 32'hA0000010);
        fwd_bus = {NO_ENT, fwd_e(1'b1, 1'b1, 1'b0, 5'd1, 32'h0)};
        settle();
        check_eq("jal_valid",  64'(ds_to_es_valid), 64'd1);
        check_eq("jal_taken",  64'(br_taken),       64'd1);
        check_eq("jal_target", 64'(br_target),      64'hA0800400);
        check_eq("jal_dest",   64'(b_dest),         64'd31);
        check_eq("jal_src1pc", 64'(b_src1_pc),      64'd1);
        fwd_bus = '0;

        // jr $31 with WB writing $31 in the same cycle
        load(r_inst(5'd31, 5'd0, 5'd0, F_JR), 32'h300);
        ws_to_rf_bus = {1'b1, 5'd31, 32'hBFC00200};
        settle();
        check_eq("jr_taken",  64'(br_taken),  64'd1);
        check_eq("jr_target", 64'(br_target), 64'hBFC00200);
        ws_to_rf_bus = '0;

        // EX back-pressure holds the payload while IF offers the next one
        load(r_inst(5'd1, 5'd2, 5'd3, F_ADDU), 32'h400);
        es_allowin = 1'b0;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {r_inst(5'd1, 5'd2, 5'd3, F_ADDU), 32'h404};
        settle();
        check_eq("hold_allowin", 64'(ds_allowin),     64'd0);
        check_eq("hold_valid",   64'(ds_to_es_valid), 64'd1);
        tick();
        check_eq("hold_pc",        64'(b_pc),           64'h400);
        check_eq("hold_valid2",    64'(ds_to_es_valid), 64'd1);
        check_eq("hold_stall_cnt", 64'(stall_cnt),      64'(exp_stall));
        es_allowin = 1'b1;
        tick();
        fs_to_ds_valid = 1'b0;
        settle();
        check_eq("release_pc",    64'(b_pc),           64'h404);
        check_eq("release_valid", 64'(ds_to_es_valid), 64'd1);

        // reset in the middle of a stall
        load(r_inst(5'd4, 5'd4, 5'd5, F_ADDU), 32'h500);
        fwd_bus = {NO_ENT, fwd_e(1'b1, 1'b1, 1'b0, 5'd4, 32'h0)};
        settle();
        check_eq("mid_stall_valid", 64'(ds_to_es_valid), 64'd0);
        tick(); exp_stall++;
        check_eq("mid_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fwd_bus = '0;
        settle();
        check_eq("mid_rst_valid",   64'(ds_to_es_valid), 64'd0);
        check_eq("mid_rst_cnt",     64'(stall_cnt),      64'd0);
        check_eq("mid_rst_allowin", 64'(ds_allowin),     64'd1);
        tick();
        check_eq("mid_rst_next_valid", 64'(ds_to_es_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
